// File: rtl/buyruk_obek_getirici.sv
// Instruction-cache refill controller: fetches one cache line as a sequence of
// word reads from main memory, assembles it and signals arrival with a pulse.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   istek_gecerli_i/adres_i      miss refill request and missed address
//   iptal_i                      cancel the refill in progress (fetch redirect)
//   mesgul_o                     controller not idle
//   buyruk_obegi_o               assembled line
//   anabellekten_obek_geldi_o    one-cycle pulse: line valid
//   bellek_istek_o/adres_o       memory word read request and address
//   bellek_istek_hazir_i         memory accepts the request
//   bellek_veri_gecerli_i/veri_i memory read data
module buyruk_obek_getirici #(
  parameter int unsigned ADRES_BIT = 32,
  parameter int unsigned VERI_BIT  = 32,
  parameter int unsigned OBEK_BIT  = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 istek_gecerli_i,
  input  logic [ADRES_BIT-1:0] istek_adres_i,
  input  logic                 iptal_i,
  output logic                 mesgul_o,
  output logic [OBEK_BIT-1:0]  buyruk_obegi_o,
  output logic                 anabellekten_obek_geldi_o,
  output logic                 bellek_istek_o,
  output logic [ADRES_BIT-1:0] bellek_adres_o,
  input  logic                 bellek_istek_hazir_i,
  input  logic                 bellek_veri_gecerli_i,
  input  logic [VERI_BIT-1:0]  bellek_veri_i
);

  localparam int unsigned BEAT_SAYISI = OBEK_BIT / VERI_BIT;
  localparam int unsigned SAYAC_BIT   = $clog2(BEAT_SAYISI);
  localparam int unsigned BAYT_BIT    = $clog2(VERI_BIT / 8);
  localparam int unsigned OFSET_BIT   = SAYAC_BIT + BAYT_BIT;
  localparam int unsigned TABAN_BIT   = ADRES_BIT - OFSET_BIT;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    ISTEK = 2'd1,
    VERI  = 2'd2,
    TAMAM = 2'd3
  } durum_e;

  durum_e                 durum_q, durum_d;
  logic [SAYAC_BIT-1:0]   sayac_q, sayac_d;
  logic [TABAN_BIT-1:0]   taban_q, taban_d;
  logic                   iptal_q, iptal_d;
  logic [OBEK_BIT-1:0]    obek_q,  obek_d;
  logic                   iptal_etkin;

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_q <= BOSTA;
      sayac_q <= '0;
      taban_q <= '0;
      iptal_q <= 1'b0;
      obek_q  <= '0;
    end else begin
      durum_q <= durum_d;
      sayac_q <= sayac_d;
      taban_q <= taban_d;
      iptal_q <= iptal_d;
      obek_q  <= obek_d;
    end
  end

  // Next-state, beat counter, cancel flag and line assembly.
  always_comb begin
    durum_d = durum_q;
    sayac_d = sayac_q;
    taban_d = taban_q;
    iptal_d = iptal_q;
    obek_d  = obek_q;
    // A cancel seen this cycle acts immediately, so no extra request is issued.
    iptal_etkin = iptal_q | iptal_i;

    if (durum_q != BOSTA) begin
      iptal_d = iptal_etkin;
    end

    unique case (durum_q)
      BOSTA: begin
        if (istek_gecerli_i && !iptal_i) begin
          taban_d = istek_adres_i[ADRES_BIT-1:OFSET_BIT];
          sayac_d = '0;
          durum_d = ISTEK;
        end
      end
      ISTEK: begin
        // Acceptance wins over a simultaneous cancel: the response must be drained.
        if (bellek_istek_hazir_i) begin
          durum_d = VERI;
        end else if (iptal_etkin) begin
          durum_d = BOSTA;
        end
      end
      VERI: begin
        if (bellek_veri_gecerli_i) begin
          for (int unsigned k = 0; k < BEAT_SAYISI; k++) begin
            if (sayac_q == SAYAC_BIT'(k)) begin
              obek_d[k*VERI_BIT +: VERI_BIT] = bellek_veri_i;
            end
          end
          if (iptal_etkin) begin
            durum_d = BOSTA;
          end else if (sayac_q == SAYAC_BIT'(BEAT_SAYISI - 1)) begin
            durum_d = TAMAM;
          end else begin
            sayac_d = sayac_q + SAYAC_BIT'(1);
            durum_d = ISTEK;
          end
        end
      end
      TAMAM: begin
        durum_d = BOSTA;
      end
      default: begin
        durum_d = BOSTA;
      end
    endcase

    if (durum_d == BOSTA) begin
      iptal_d = 1'b0;
    end
  end

  // Outputs decoded from registered state only.
  assign mesgul_o                  = (durum_q != BOSTA);
  assign bellek_istek_o            = (durum_q == ISTEK);
  assign anabellekten_obek_geldi_o = (durum_q == TAMAM);
  assign buyruk_obegi_o            = obek_q;
  // Word select concatenates into the offset field, so it never carries upward.
  assign bellek_adres_o = (durum_q == ISTEK) ? {taban_q, sayac_q, BAYT_BIT'(0)}
                                             : '0;

endmodule

// File: tb/tb_buyruk_obek_getirici.sv
module tb_buyruk_obek_getirici;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         istek_gecerli = 1'b0;
  logic [31:0]  istek_adres = '0;
  logic         iptal = 1'b0;
  logic         mesgul;
  logic [127:0] obek;
  logic         geldi;
  logic         b_istek;
  logic [31:0]  b_adres;
  logic         hazir = 1'b0;
  logic         vgecerli = 1'b0;
  logic [31:0]  veri = '0;

  int n_chk  = 0;
  int n_fail = 0;
  int unsigned kenar = 0;

  // Results of the last refill run.
  int           r_e0, r_pulses, r_pulse_cyc, r_accepts, r_idle_cyc, r_data_cyc;
  int           r_cancel_cyc, r_bad_addr;
  logic [127:0] r_line, r_exp_line;

  buyruk_obek_getirici dut (
    .clk_i                     (clk),
    .rst_i                     (rst),
    .istek_gecerli_i           (istek_gecerli),
    .istek_adres_i             (istek_adres),
    .iptal_i                   (iptal),
    .mesgul_o                  (mesgul),
    .buyruk_obegi_o            (obek),
    .anabellekten_obek_geldi_o (geldi),
    .bellek_istek_o            (b_istek),
    .bellek_adres_o            (b_adres),
    .bellek_istek_hazir_i      (hazir),
    .bellek_veri_gecerli_i     (vgecerli),
    .bellek_veri_i             (veri)
  );

  always #5 clk = ~clk;
  always @(posedge clk) kenar <= kenar + 1;

  // Behavioural memory + requester. mode: 0 normal, 1 cancel in ISTEK of beat cb,
  // 2 cancel in VERI of beat cb, 3 cancel while the pulse is shown.
  task automatic refill(input logic [31:0] a, input int hw, input int dw,
                        input int mode, input int cb,
                        input bit hold_next, input logic [31:0] next_a);
    logic [31:0] taban;
    logic [31:0] w [4];
    int beat, phase, wcnt, dcnt, cyc;
    bit done;
    taban = a & 32'hFFFF_FFF0;
    for (int i = 0; i < 4; i++) w[i] = '0;
    r_pulses = 0; r_accepts = 0; r_pulse_cyc = -1; r_idle_cyc = -1;
    r_data_cyc = -1; r_cancel_cyc = -1; r_bad_addr = 0; r_line = '0;
    istek_gecerli = 1'b1; istek_adres = a;
    cyc = 0;
    while (mesgul !== 1'b1 && cyc < 30) begin
      @(posedge clk); #1; cyc++;
    end
    istek_gecerli = 1'b0;
    if (mesgul !== 1'b1) begin
      n_chk++; n_fail++;
      $display("FAIL refill_start: mesgul=%b required 1 within 30 cycles", mesgul);
      return;
    end
    r_e0 = int'(kenar);
    beat = 0; phase = 0; wcnt = 0; dcnt = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 200) begin
      iptal = 1'b0; vgecerli = 1'b0;
      if (hazir) begin phase = 1; dcnt = 0; hazir = 1'b0; r_accepts++; end
      if (geldi === 1'b1) begin
        r_pulses++; r_pulse_cyc = cyc; r_line = obek;
        if (mode == 3) iptal = 1'b1;
        if (hold_next) begin istek_gecerli = 1'b1; istek_adres = next_a; end
      end
      if (mesgul === 1'b0) begin
        r_idle_cyc = cyc; done = 1'b1;
      end else if (b_istek === 1'b1) begin
        if (b_adres !== taban + 32'(4 * beat)) r_bad_addr++;
        if (mode == 1 && beat == cb) begin
          iptal = 1'b1; r_cancel_cyc = cyc;
        end else if (wcnt >= hw) begin
          hazir = 1'b1; wcnt = 0;
        end else begin
          wcnt++;
        end
      end else if (phase == 1) begin
        if (mode == 2 && beat == cb && dcnt == 0) iptal = 1'b1;
        if (dcnt >= dw) begin
          vgecerli = 1'b1; veri = $urandom;
          if (beat < 4) w[beat] = veri;
          r_data_cyc = cyc; beat++; phase = 0;
        end else begin
          dcnt++;
        end
      end
      if (!done) begin @(posedge clk); #1; cyc++; end
    end
    iptal = 1'b0; vgecerli = 1'b0; hazir = 1'b0;
    r_exp_line = {w[3], w[2], w[1], w[0]};
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL refill_timeout: controller still busy after 200 cycles");
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #2;
    n_chk++; if (mesgul !== 1'b0) begin n_fail++; $display("FAIL reset_mesgul: got %b required 0", mesgul); end
    n_chk++; if (b_istek !== 1'b0) begin n_fail++; $display("FAIL reset_istek: got %b required 0", b_istek); end
    n_chk++; if (geldi !== 1'b0) begin n_fail++; $display("FAIL reset_geldi: got %b required 0", geldi); end
    n_chk++; if (b_adres !== 32'd0) begin n_fail++; $display("FAIL reset_adres: got %h required 0", b_adres); end
    n_chk++; if (obek !== 128'd0) begin n_fail++; $display("FAIL reset_obek: got %h required 0", obek); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_burst;
    istek_gecerli = 1'b1; istek_adres = 32'h0000_4560;
    @(posedge clk); #1;
    istek_gecerli = 1'b0;
    for (int s = 0; s < 5; s++) begin
      hazir    = (s % 2 == 0);
      vgecerli = (s % 2 == 1);
      veri     = $urandom | 32'h1;
      @(posedge clk); #1;
    end
    hazir = 1'b0; vgecerli = 1'b0;
    n_chk++; if (mesgul !== 1'b1) begin n_fail++; $display("FAIL midrst_busy: mesgul=%b required 1", mesgul); end
    #2 rst = 1'b0;
    #1;
    n_chk++; if (mesgul !== 1'b0) begin n_fail++; $display("FAIL midrst_mesgul: got %b required 0", mesgul); end
    n_chk++; if (b_istek !== 1'b0) begin n_fail++; $display("FAIL midrst_istek: got %b required 0", b_istek); end
    n_chk++; if (obek !== 128'd0) begin n_fail++; $display("FAIL midrst_obek: got %h required 0", obek); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    vgecerli = 1'b1; veri = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    vgecerli = 1'b0;
    n_chk++; if (geldi !== 1'b0) begin n_fail++; $display("FAIL stray_geldi: got %b required 0", geldi); end
    n_chk++; if (obek !== 128'd0) begin n_fail++; $display("FAIL stray_obek: got %h required 0", obek); end
    n_chk++; if (mesgul !== 1'b0) begin n_fail++; $display("FAIL stray_mesgul: got %b required 0", mesgul); end
  endtask

  task automatic test_basic;
    refill(32'h0000_1238, 0, 0, 0, 0, 1'b0, '0);
    n_chk++; if (r_bad_addr != 0) begin n_fail++; $display("FAIL basic_addr: %0d bad addresses required 0", r_bad_addr); end
    n_chk++; if (r_accepts != 4) begin n_fail++; $display("FAIL basic_accepts: got %0d required 4", r_accepts); end
    n_chk++; if (r_pulses != 1) begin n_fail++; $display("FAIL basic_pulses: got %0d required 1", r_pulses); end
    n_chk++; if (r_pulse_cyc != 8) begin n_fail++; $display("FAIL basic_pulse_edge: got E%0d required E8", r_pulse_cyc); end
    n_chk++; if (r_line !== r_exp_line) begin n_fail++; $display("FAIL basic_line: got %h required %h", r_line, r_exp_line); end
    n_chk++; if (r_idle_cyc != 9) begin n_fail++; $display("FAIL basic_idle: got E%0d required E9", r_idle_cyc); end
    n_chk++; if (obek !== r_exp_line) begin n_fail++; $display("FAIL basic_hold: got %h required %h", obek, r_exp_line); end
  endtask

  task automatic test_wait_states;
    refill(32'h8000_00A4, 3, 2, 0, 0, 1'b0, '0);
    n_chk++; if (r_bad_addr != 0) begin n_fail++; $display("FAIL wait_addr: %0d bad addresses required 0", r_bad_addr); end
    n_chk++; if (r_pulses != 1) begin n_fail++; $display("FAIL wait_pulses: got %0d required 1", r_pulses); end
    n_chk++; if (r_line !== r_exp_line) begin n_fail++; $display("FAIL wait_line: got %h required %h", r_line, r_exp_line); end
  endtask

  task automatic test_cancel_istek;
    refill(32'h0000_2000, 2, 1, 1, 1, 1'b0, '0);
    n_chk++; if (r_pulses != 0) begin n_fail++; $display("FAIL cist_pulses: got %0d required 0", r_pulses); end
    n_chk++; if (r_accepts != 1) begin n_fail++; $display("FAIL cist_accepts: got %0d required 1", r_accepts); end
    n_chk++; if (r_idle_cyc != r_cancel_cyc + 1) begin n_fail++; $display("FAIL cist_idle: idle at %0d required %0d", r_idle_cyc, r_cancel_cyc + 1); end
    n_chk++; if (b_istek !== 1'b0) begin n_fail++; $display("FAIL cist_istek_drop: got %b required 0", b_istek); end
  endtask

  task automatic test_cancel_veri;
    refill(32'h0000_3010, 0, 2, 2, 1, 1'b0, '0);
    n_chk++; if (r_pulses != 0) begin n_fail++; $display("FAIL cveri_pulses: got %0d required 0", r_pulses); end
    n_chk++; if (r_accepts != 2) begin n_fail++; $display("FAIL cveri_accepts: got %0d required 2", r_accepts); end
    n_chk++; if (r_idle_cyc != r_data_cyc + 1) begin n_fail++; $display("FAIL cveri_idle: idle at %0d required %0d", r_idle_cyc, r_data_cyc + 1); end
    repeat (3) begin
      @(posedge clk); #1;
      n_chk++; if (b_istek !== 1'b0 || geldi !== 1'b0) begin n_fail++; $display("FAIL cveri_quiet: istek=%b geldi=%b required 0 0", b_istek, geldi); end
    end
  endtask

  task automatic test_cancel_bosta;
    istek_gecerli = 1'b1; istek_adres = 32'h0000_5000; iptal = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      n_chk++; if (mesgul !== 1'b0) begin n_fail++; $display("FAIL cbosta_mesgul: got %b required 0", mesgul); end
    end
    istek_gecerli = 1'b0; iptal = 1'b0;
  endtask

  task automatic test_cancel_tamam;
    refill(32'h0000_6004, 0, 0, 3, 0, 1'b0, '0);
    n_chk++; if (r_pulses != 1) begin n_fail++; $display("FAIL ctamam_pulses: got %0d required 1", r_pulses); end
    n_chk++; if (r_line !== r_exp_line) begin n_fail++; $display("FAIL ctamam_line: got %h required %h", r_line, r_exp_line); end
    refill(32'h0000_7008, 0, 0, 0, 0, 1'b0, '0);
    n_chk++; if (r_pulses != 1 || r_pulse_cyc != 8) begin n_fail++; $display("FAIL ctamam_after: pulses=%0d at E%0d required 1 at E8", r_pulses, r_pulse_cyc); end
  endtask

  task automatic test_back_to_back;
    int e0a;
    logic [127:0] la;
    refill(32'hFFFF_FFF0, 0, 0, 0, 0, 1'b1, 32'h0000_0000);
    e0a = r_e0; la = r_exp_line;
    n_chk++; if (r_bad_addr != 0) begin n_fail++; $display("FAIL b2b_wrap_addr: %0d bad addresses required 0", r_bad_addr); end
    n_chk++; if (r_pulses != 1 || r_line !== la) begin n_fail++; $display("FAIL b2b_first: pulses=%0d line=%h required 1 %h", r_pulses, r_line, la); end
    refill(32'h0000_0000, 0, 0, 0, 0, 1'b0, '0);
    n_chk++; if (r_e0 - e0a != 10) begin n_fail++; $display("FAIL b2b_accept: second accepted at E%0d required E10", r_e0 - e0a); end
    n_chk++; if (r_bad_addr != 0) begin n_fail++; $display("FAIL b2b_addr2: %0d bad addresses required 0", r_bad_addr); end
    n_chk++; if (r_pulses != 1 || r_line !== r_exp_line) begin n_fail++; $display("FAIL b2b_second: pulses=%0d line=%h required 1 %h", r_pulses, r_line, r_exp_line); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) begin
      refill($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, 0, 1'b0, '0);
      n_chk++; if (r_bad_addr != 0) begin n_fail++; $display("FAIL rand_addr[%0d]: %0d bad addresses required 0", i, r_bad_addr); end
      n_chk++; if (r_pulses != 1 || r_line !== r_exp_line) begin n_fail++; $display("FAIL rand_line[%0d]: pulses=%0d line=%h required 1 %h", i, r_pulses, r_line, r_exp_line); end
    end
  endtask

  initial begin
    test_reset;
    test_reset_mid_burst;
    test_basic;
    test_wait_states;
    test_cancel_istek;
    test_cancel_veri;
    test_cancel_bosta;
    test_cancel_tamam;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
